// File: rtl/lsu_misalign_sequencer_pkg.sv
// Shared widths, func3 encodings and FSM states for the misaligned load/store sequencer.
// Also holds the request classification helpers used when a request is accepted.
package lsu_misalign_sequencer_pkg;

    localparam int Func3Width   = 3;
    localparam int MemAddrWidth = 12;
    localparam int DataWidth    = 32;

    localparam logic [Func3Width-1:0] F3_LB  = 3'd0;
    localparam logic [Func3Width-1:0] F3_LH  = 3'd1;
    localparam logic [Func3Width-1:0] F3_LW  = 3'd2;
    localparam logic [Func3Width-1:0] F3_LBU = 3'd4;
    localparam logic [Func3Width-1:0] F3_LHU = 3'd5;
    localparam logic [Func3Width-1:0] F3_SB  = 3'd0;
    localparam logic [Func3Width-1:0] F3_SH  = 3'd1;
    localparam logic [Func3Width-1:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic func3_legal(input logic write, input logic [Func3Width-1:0] f3);
        if (write) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) || (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // Index of the last beat: 0 for a single access, 1 for a split half, 3 for a split word.
    function automatic logic [1:0] last_beat(input logic [Func3Width-1:0] f3, input logic [1:0] offset);
        case (f3[1:0])
            2'd1:    return (offset == 2'd3) ? 2'd1 : 2'd0;
            2'd2:    return (offset == 2'd0) ? 2'd0 : 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_misalign_sequencer_load_extend.sv
// Sign/zero extension of a right-aligned little-endian load assembly.
// Also used by writeback formatting, so it stays purely combinational.
module lsu_load_extend
    import lsu_misalign_sequencer_pkg::*;
(
    input  logic [Func3Width-1:0] i_func3,
    input  logic [DataWidth-1:0]  i_raw,
    output logic [DataWidth-1:0]  o_data
);

    always_comb begin
        o_data = i_raw;
        case (i_func3)
            F3_LB:   o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            F3_LH:   o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            F3_LBU:  o_data = {24'd0, i_raw[7:0]};
            F3_LHU:  o_data = {16'd0, i_raw[15:0]};
            default: o_data = i_raw;
        endcase
    end

endmodule

// File: rtl/lsu_misalign_sequencer.sv
// Data-memory initiator: splits word-crossing loads/stores into byte beats and
// reassembles split loads. Handshake: a request transfers on a cycle where reqValid && reqReady.
module lsu_misalign_sequencer
    import lsu_misalign_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_reqValid,
    output logic                  o_reqReady,
    input  logic                  i_reqWrite,
    input  logic [2:0]            i_reqFunc3,
    input  logic [ADDR_WIDTH-1:0] i_reqAddr,
    input  logic [DATA_WIDTH-1:0] i_reqWData,
    output logic                  o_respValid,
    output logic                  o_respErr,
    output logic [DATA_WIDTH-1:0] o_respRData,
    output logic                  o_memWriteEnable,
    output logic [2:0]            o_memFunc3,
    output logic [ADDR_WIDTH-1:0] o_memAddr,
    output logic [DATA_WIDTH-1:0] o_memWriteData,
    input  logic [DATA_WIDTH-1:0] i_memReadData,
    output state_t                o_dbgState
);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_write;
    logic [2:0]              r_func3;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_err;
    logic                    r_split;
    logic [1:0]              r_last;
    logic [1:0]              r_beat;
    logic [DATA_WIDTH-1:0]   r_asm;
    logic [DATA_WIDTH-1:0]   w_ext;
    logic                    w_legal;

    assign w_legal = func3_legal(i_reqWrite, i_reqFunc3);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_write <= 1'b0;
            r_func3 <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_split <= 1'b0;
            r_last  <= '0;
            r_beat  <= '0;
            r_asm   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: if (i_reqValid) begin
                    r_write <= i_reqWrite;
                    r_func3 <= i_reqFunc3;
                    r_addr  <= i_reqAddr;
                    r_wdata <= i_reqWData;
                    r_err   <= !w_legal;
                    r_last  <= last_beat(i_reqFunc3, i_reqAddr[1:0]);
                    r_split <= last_beat(i_reqFunc3, i_reqAddr[1:0]) != 2'd0;
                    r_beat  <= '0;
                    r_asm   <= '0;
                end
                ST_BEAT: begin
                    r_beat <= r_beat + 2'd1;
                    if (!r_write) begin
                        if (r_split) r_asm[{r_beat, 3'b000} +: 8] <= i_memReadData[7:0];
                        else         r_asm <= i_memReadData;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (i_reqValid) w_next = w_legal ? ST_BEAT : ST_RESP;
            ST_BEAT: if (r_beat == r_last) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    lsu_load_extend u_extend (
        .i_func3 (r_func3),
        .i_raw   (r_asm),
        .o_data  (w_ext)
    );

    // Memory outputs are zero outside BEAT; a reset in the middle of a beat cancels its write.
    always_comb begin
        o_reqReady       = (r_state == ST_IDLE);
        o_respValid      = (r_state == ST_RESP);
        o_respErr        = (r_state == ST_RESP) && r_err;
        o_respRData      = ((r_state == ST_RESP) && !r_err && !r_write) ? w_ext : '0;
        o_memWriteEnable = 1'b0;
        o_memFunc3       = '0;
        o_memAddr        = '0;
        o_memWriteData   = '0;
        if (r_state == ST_BEAT) begin
            o_memWriteEnable = r_write && !i_rst;
            o_memAddr        = r_addr + ADDR_WIDTH'(r_beat);
            o_memFunc3       = r_split ? (r_write ? F3_SB : F3_LBU) : r_func3;
            o_memWriteData   = r_split ? {24'd0, r_wdata[{r_beat, 3'b000} +: 8]} : r_wdata;
        end
        o_dbgState = r_state;
    end

endmodule

// File: tb/tb_lsu_misalign_sequencer.sv
// Bench for lsu_misalign_sequencer: byte-array memory model, beat and response scoreboards.
module tb_lsu_misalign_sequencer;
  import lsu_misalign_sequencer_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [2:0]    req_func3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_err;
  logic [DW-1:0] resp_rdata;
  logic          mem_we;
  logic [2:0]    mem_func3;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  state_t        dbg_state;

  logic [7:0]    mem [0:4095];
  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;

  int checks = 0;
  int errors = 0;
  logic [DW:0]        exp_resp_q[$];
  logic [DW+AW+3:0]   exp_beat_q[$];

  always #5 clk = ~clk;

  lsu_misalign_sequencer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_reqValid       (req_valid),
    .o_reqReady       (req_ready),
    .i_reqWrite       (req_write),
    .i_reqFunc3       (req_func3),
    .i_reqAddr        (req_addr),
    .i_reqWData       (req_wdata),
    .o_respValid      (resp_valid),
    .o_respErr        (resp_err),
    .o_respRData      (resp_rdata),
    .o_memWriteEnable (mem_we),
    .o_memFunc3       (mem_func3),
    .o_memAddr        (mem_addr),
    .o_memWriteData   (mem_wdata),
    .i_memReadData    (mem_rdata),
    .o_dbgState       (dbg_state)
  );

  // memory model: combinational read, right-aligned, no extension
  always_comb begin
    mem_rdata = '0;
    case (mem_func3)
      3'd0, 3'd4: mem_rdata = {24'd0, mem[mem_addr]};
      3'd1, 3'd5: mem_rdata = {16'd0, mem[mem_addr + AW'(1)], mem[mem_addr]};
      3'd2: mem_rdata = {mem[mem_addr + AW'(3)], mem[mem_addr + AW'(2)],
                         mem[mem_addr + AW'(1)], mem[mem_addr]};
      default: mem_rdata = '0;
    endcase
  end

  always @(posedge clk) begin
    if (pre_we) begin
      for (int i = 0; i < 4; i++) mem[pre_addr + AW'(i)] <= pre_data[8*i +: 8];
    end else if (mem_we) begin
      case (mem_func3)
        3'd0: mem[mem_addr] <= mem_wdata[7:0];
        3'd1: for (int i = 0; i < 2; i++) mem[mem_addr + AW'(i)] <= mem_wdata[8*i +: 8];
        3'd2: for (int i = 0; i < 4; i++) mem[mem_addr + AW'(i)] <= mem_wdata[8*i +: 8];
        default: ;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [DW+AW+3:0] eb;
    logic [DW:0]      er;
    if (dbg_state == ST_BEAT) begin
      if (exp_beat_q.size() == 0) check_val("unexpected_beat", {mem_addr}, 0);
      else begin
        eb = exp_beat_q.pop_front();
        check_val("beat", {mem_we, mem_func3, mem_addr, mem_wdata}, eb);
      end
    end else if (mem_we) begin
      check_val("we_outside_beat", 1, 0);
    end
    if (resp_valid) begin
      if (exp_resp_q.size() == 0) check_val("unexpected_resp", {resp_err, resp_rdata}, 0);
      else begin
        er = exp_resp_q.pop_front();
        check_val("resp", {resp_err, resp_rdata}, er);
      end
    end
  end

  task automatic set_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  function automatic logic [DW-1:0] get_word(input logic [AW-1:0] a);
    return {mem[a + AW'(3)], mem[a + AW'(2)], mem[a + AW'(1)], mem[a]};
  endfunction

  task automatic push_beat(input logic w, input logic [2:0] f3, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd);
    exp_beat_q.push_back({w, f3, a, wd});
  endtask

  task automatic do_req(input logic w, input logic [2:0] f3, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int nb, input logic err,
                        input logic [DW-1:0] rdata);
    int   n;
    logic done;
    if (nb == 1) push_beat(w, f3, a, wd);
    else for (int k = 0; k < nb; k++)
      push_beat(w, w ? 3'd0 : 3'd4, a + AW'(k), {24'd0, wd[8*k +: 8]});
    exp_resp_q.push_back({err, rdata});
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_write = w; req_func3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid) done = 1'b1;
    end
    check_val("latency", n, nb + 1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [7:0]    rb;
    logic [2:0]    rf;
    logic [15:0]   rh;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_func3 = '0;
    req_addr = '0; req_wdata = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_outputs", {req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_func3},
              {1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 3'd0});
    check_val("rst_mem_bus", {mem_addr, mem_wdata}, 0);
    check_val("rst_state", dbg_state, ST_IDLE);
    #1 rst = 1'b0;

    set_word(12'h100, 32'h8899AABB);
    set_word(12'h104, 32'hCCDDEEFF);
    do_req(1'b0, F3_LW,  12'h101, 32'd0, 4, 1'b0, 32'hFF8899AA);
    do_req(1'b0, F3_LH,  12'h103, 32'd0, 2, 1'b0, 32'hFFFFFF88);
    do_req(1'b0, F3_LHU, 12'h103, 32'd0, 2, 1'b0, 32'h0000FF88);
    do_req(1'b0, F3_LH,  12'h102, 32'd0, 1, 1'b0, 32'hFFFF8899);
    do_req(1'b0, F3_LW,  12'h100, 32'd0, 1, 1'b0, 32'h8899AABB);
    do_req(1'b0, F3_LB,  12'h103, 32'd0, 1, 1'b0, 32'hFFFFFF88);

    do_req(1'b1, F3_SW, 12'h102, 32'hDEADBEEF, 4, 1'b0, 32'd0);
    @(negedge clk);
    check_val("sw_word100", get_word(12'h100), 32'hBEEFAABB);
    check_val("sw_word104", get_word(12'h104), 32'hCCDDDEAD);

    set_word(12'hFFC, 32'h11223344);
    set_word(12'h000, 32'h55667788);
    do_req(1'b0, F3_LW, 12'hFFE, 32'd0, 4, 1'b0, 32'h77881122);

    do_req(1'b0, 3'd3, 12'h100, 32'd0, 0, 1'b1, 32'd0);
    do_req(1'b1, 3'd4, 12'h100, 32'h12345678, 0, 1'b1, 32'd0);

    // random byte loads and split half loads over a random region
    for (int j = 0; j < 4; j++) set_word(12'h200 + AW'(4 * j), $urandom);
    for (int j = 0; j < 6; j++) begin
      ra = 12'h200 + AW'($urandom_range(0, 15));
      rb = mem[ra];
      rf = ($urandom_range(0, 1) == 1) ? F3_LB : F3_LBU;
      do_req(1'b0, rf, ra, 32'd0, 1, 1'b0,
             (rf == F3_LB) ? {{24{rb[7]}}, rb} : {24'd0, rb});
    end
    for (int j = 0; j < 3; j++) begin
      ra = 12'h203 + AW'(4 * $urandom_range(0, 2));
      rh = {mem[ra + AW'(1)], mem[ra]};
      do_req(1'b0, F3_LH, ra, 32'd0, 2, 1'b0, {{16{rh[15]}}, rh});
    end

    // reset during the third beat of a split store
    set_word(12'h100, 32'h8899AABB);
    set_word(12'h104, 32'hCCDDEEFF);
    push_beat(1'b1, 3'd0, 12'h101, 32'h78);
    push_beat(1'b1, 3'd0, 12'h102, 32'h56);
    push_beat(1'b0, 3'd0, 12'h103, 32'h34);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_func3 = F3_SW; req_addr = 12'h101;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_mid_state", dbg_state, ST_IDLE);
    check_val("rst_mid_ready", req_ready, 1'b1);
    check_val("rst_mid_word100", get_word(12'h100), 32'h885678BB);
    check_val("rst_mid_word104", get_word(12'h104), 32'hCCDDEEFF);
    do_req(1'b0, F3_LW, 12'h100, 32'd0, 1, 1'b0, 32'h885678BB);

    repeat (3) @(negedge clk);
    check_val("beat_q_drained", exp_beat_q.size(), 0);
    check_val("resp_q_drained", exp_resp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
